// File: rtl/speicher_pkg.sv
// Shared definitions for the RAM access controller: FSM states, requester tags
// and the address-width helper.
package speicher_pkg;

    typedef enum logic [1:0] {
        LEERLAUF = 2'd0,
        ZUGRIFF  = 2'd1,
        ERFASSEN = 2'd2
    } zustand_t;

    typedef enum logic {
        QUELLE_BEFEHL = 1'b0,
        QUELLE_DATEN  = 1'b1
    } quelle_t;

    function automatic int adressbreite(input int worte);
        return (worte > 1) ? $clog2(worte) : 1;
    endfunction

endpackage

// File: rtl/ram_zugriffssteuerung_if.sv
// Core-side request/response bundle. Handshake: a request transfers in the cycle
// where Anfrage and Bereit are both 1; responses are one-cycle Gueltig pulses with no backpressure.
interface ram_zugriffssteuerung_if
    import speicher_pkg::*;
#(
    parameter int WORDSIZE = 32,
    parameter int WORDS    = 256
);
    localparam int ADDRWIDTH = adressbreite(WORDS);

    logic                 BefehlAnfrage;
    logic [ADDRWIDTH-1:0] BefehlAdresse;
    logic                 BefehlBereit;
    logic                 BefehlGueltig;
    logic [WORDSIZE-1:0]  BefehlDaten;

    logic                 DatenAnfrage;
    logic                 DatenSchreiben;
    logic [ADDRWIDTH-1:0] DatenAdresse;
    logic [WORDSIZE-1:0]  DatenSchreibwert;
    logic                 DatenBereit;
    logic                 DatenGueltig;
    logic [WORDSIZE-1:0]  DatenLesewert;

    modport master (
        output BefehlAnfrage, BefehlAdresse,
        output DatenAnfrage, DatenSchreiben, DatenAdresse, DatenSchreibwert,
        input  BefehlBereit, BefehlGueltig, BefehlDaten,
        input  DatenBereit, DatenGueltig, DatenLesewert
    );

    modport slave (
        input  BefehlAnfrage, BefehlAdresse,
        input  DatenAnfrage, DatenSchreiben, DatenAdresse, DatenSchreibwert,
        output BefehlBereit, BefehlGueltig, BefehlDaten,
        output DatenBereit, DatenGueltig, DatenLesewert
    );

endinterface

// File: rtl/zugriff_arbiter.sv
// Two-requester round-robin arbiter; the last-grant register only moves when a
// grant is actually taken while enabled.
module zugriff_arbiter
    import speicher_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    freigabe_i,
    input  logic    anfrage_befehl_i,
    input  logic    anfrage_daten_i,
    output logic    bereit_befehl_o,
    output logic    bereit_daten_o,
    output quelle_t gewinner_o
);

    quelle_t letzter_q, letzter_d;
    quelle_t wahl;

    always_comb begin
        wahl = QUELLE_DATEN;
        if (anfrage_befehl_i && anfrage_daten_i) begin
            wahl = (letzter_q == QUELLE_BEFEHL) ? QUELLE_DATEN : QUELLE_BEFEHL;
        end else if (anfrage_befehl_i) begin
            wahl = QUELLE_BEFEHL;
        end
        bereit_befehl_o = freigabe_i && anfrage_befehl_i && (wahl == QUELLE_BEFEHL);
        bereit_daten_o  = freigabe_i && anfrage_daten_i && (wahl == QUELLE_DATEN);
        gewinner_o      = wahl;
        letzter_d       = (bereit_befehl_o || bereit_daten_o) ? wahl : letzter_q;
    end

    // Starting from "fetch granted last" lets data win the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            letzter_q <= QUELLE_BEFEHL;
        end else begin
            letzter_q <= letzter_d;
        end
    end

endmodule

// File: rtl/ram_zugriffssteuerung.sv
// Initiator for a single-port synchronous RAM: arbitrates fetch and load/store
// requests, sequences each access over three cycles and returns the read word.
module ram_zugriffssteuerung
    import speicher_pkg::*;
#(
    parameter int WORDSIZE = 32,
    parameter int WORDS    = 256,
    localparam int ADDRWIDTH = adressbreite(WORDS)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    ram_zugriffssteuerung_if.slave kern,
    output logic                   SchreibenAn,
    output logic [WORDSIZE-1:0]    DatenRein,
    output logic [ADDRWIDTH-1:0]   Adresse,
    input  logic [WORDSIZE-1:0]    DatenRaus,
    output zustand_t               Zustand
);

    localparam logic [ADDRWIDTH:0] GRENZE = (ADDRWIDTH + 1)'(WORDS);

    zustand_t             zustand_q;
    quelle_t              besitzer_q;
    quelle_t              gewinner;
    logic                 schreiben_q;
    logic                 speichern_q;
    logic                 im_bereich_q;
    logic [ADDRWIDTH-1:0] adresse_q;
    logic [WORDSIZE-1:0]  datenrein_q;
    logic [WORDSIZE-1:0]  befehl_daten_q;
    logic [WORDSIZE-1:0]  daten_lese_q;
    logic                 befehl_gueltig_q;
    logic                 daten_gueltig_q;
    logic                 bereit_befehl;
    logic                 bereit_daten;
    logic                 freigabe;
    logic [ADDRWIDTH-1:0] neue_adresse;
    logic                 neu_im_bereich;

    assign freigabe = (zustand_q == LEERLAUF) && !Reset;

    zugriff_arbiter u_arbiter (
        .clk_i            (Clock),
        .rst_i            (Reset),
        .freigabe_i       (freigabe),
        .anfrage_befehl_i (kern.BefehlAnfrage),
        .anfrage_daten_i  (kern.DatenAnfrage),
        .bereit_befehl_o  (bereit_befehl),
        .bereit_daten_o   (bereit_daten),
        .gewinner_o       (gewinner)
    );

    // Addresses beyond WORDS exist only for non-power-of-two depths.
    assign neue_adresse   = bereit_daten ? kern.DatenAdresse : kern.BefehlAdresse;
    assign neu_im_bereich = {1'b0, neue_adresse} < GRENZE;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            zustand_q        <= LEERLAUF;
            besitzer_q       <= QUELLE_BEFEHL;
            schreiben_q      <= 1'b0;
            speichern_q      <= 1'b0;
            im_bereich_q     <= 1'b0;
            adresse_q        <= '0;
            datenrein_q      <= '0;
            befehl_daten_q   <= '0;
            daten_lese_q     <= '0;
            befehl_gueltig_q <= 1'b0;
            daten_gueltig_q  <= 1'b0;
        end else begin
            befehl_gueltig_q <= 1'b0;
            daten_gueltig_q  <= 1'b0;
            unique case (zustand_q)
                LEERLAUF: begin
                    if (bereit_befehl || bereit_daten) begin
                        zustand_q    <= ZUGRIFF;
                        besitzer_q   <= gewinner;
                        adresse_q    <= neue_adresse;
                        im_bereich_q <= neu_im_bereich;
                        speichern_q  <= bereit_daten && kern.DatenSchreiben;
                        schreiben_q  <= bereit_daten && kern.DatenSchreiben && neu_im_bereich;
                        if (bereit_daten) begin
                            datenrein_q <= kern.DatenSchreibwert;
                        end
                    end
                end
                ZUGRIFF: begin
                    schreiben_q <= 1'b0;
                    zustand_q   <= ERFASSEN;
                end
                ERFASSEN: begin
                    zustand_q <= LEERLAUF;
                    if (besitzer_q == QUELLE_BEFEHL) begin
                        befehl_gueltig_q <= 1'b1;
                        befehl_daten_q   <= im_bereich_q ? DatenRaus : '0;
                    end else begin
                        daten_gueltig_q <= 1'b1;
                        if (!speichern_q) begin
                            daten_lese_q <= im_bereich_q ? DatenRaus : '0;
                        end
                    end
                end
                default: zustand_q <= LEERLAUF;
            endcase
        end
    end

    assign kern.BefehlBereit  = bereit_befehl;
    assign kern.DatenBereit   = bereit_daten;
    assign kern.BefehlGueltig = befehl_gueltig_q;
    assign kern.DatenGueltig  = daten_gueltig_q;
    assign kern.BefehlDaten   = befehl_daten_q;
    assign kern.DatenLesewert = daten_lese_q;
    assign SchreibenAn        = schreiben_q;
    assign DatenRein          = datenrein_q;
    assign Adresse            = adresse_q;
    assign Zustand            = zustand_q;

endmodule
